// File: rtl/reg_file_32x32_pkg.sv
// Shared datapath types for the single-cycle core:
// word/register-address widths and the hardwired zero register.
package reg_file_32x32_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = 5'd0;
endpackage

// File: rtl/reg_file_32x32_wr_decoder.sv
// One-hot write-enable decoder for the register file.
// Bit for the zero register is never set.
module reg_wr_decoder
  import reg_file_32x32_pkg::*;
#(
  parameter int ADDR_W   = reg_file_32x32_pkg::ADDR_W,
  parameter int NUM_REGS = reg_file_32x32_pkg::NUM_REGS
) (
  input  logic                i_wr_en,
  input  logic [ADDR_W-1:0]   i_wr_addr,
  output logic [NUM_REGS-1:0] o_we
);

  always_comb begin
    o_we = '0;
    if (i_wr_en)
      o_we[i_wr_addr] = 1'b1;
    o_we[ZERO_REG] = 1'b0;
  end

endmodule

// File: rtl/reg_file_32x32.sv
// 2R1W 32x32 register file, r0 hardwired to zero.
// Define REGFILE_WR_BYPASS_EN for same-cycle write-through reads.
module reg_file_32x32
  import reg_file_32x32_pkg::*;
#(
  parameter int DATA_W   = reg_file_32x32_pkg::DATA_W,
  parameter int ADDR_W   = reg_file_32x32_pkg::ADDR_W,
  parameter int NUM_REGS = reg_file_32x32_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [7:0]        wr_count
);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [7:0]          r_wr_count;
  logic [NUM_REGS-1:0] w_we;

  reg_wr_decoder #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_dec (
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .o_we      (w_we)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        r_regs[i] <= '0;
      r_wr_count <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++)
        if (w_we[i])
          r_regs[i] <= wr_data;
      if (|w_we)
        r_wr_count <= r_wr_count + 8'd1;
    end
  end

`ifdef REGFILE_WR_BYPASS_EN
  logic w_byp1;
  logic w_byp2;

  // w_we already excludes r0, so bypass never leaks onto address 0
  assign w_byp1 = !rst && w_we[rd_addr1];
  assign w_byp2 = !rst && w_we[rd_addr2];

  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    if (rd_addr1 != '0)
      rd_data1 = w_byp1 ? wr_data : r_regs[rd_addr1];
    if (rd_addr2 != '0)
      rd_data2 = w_byp2 ? wr_data : r_regs[rd_addr2];
  end
`else
  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    if (rd_addr1 != '0)
      rd_data1 = r_regs[rd_addr1];
    if (rd_addr2 != '0)
      rd_data2 = r_regs[rd_addr2];
  end
`endif

  assign wr_count = r_wr_count;

endmodule
